bus_mem_ctrl: RTL

- Memory-side slave for the CPU core's DataBus master port (read/write/addr/dataOut/memType in, dataIn/ready out).
- Converts BYTE/HALF/WORD requests into word-wide accesses on a synchronous single-port SRAM with byte enables.
- Inserts programmable wait states and flags misaligned or out-of-range accesses.
- Sits directly downstream of the CPU core.

---
 rtl/bus_mem_ctrl_pkg.sv | 22 ++
 rtl/bus_mem_ctrl_lane.sv | 45 ++++
 rtl/bus_mem_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bus_mem_ctrl_pkg.sv
// Shared types for the DataBus memory-side slave: bus access sizes,
// controller states and the wait-state counter width.
package bus_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } MemType;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    CAPTURE,
    DONE,
    RECOVER
  } BusCtrlState;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/bus_mem_ctrl_lane.sv
// Byte-lane steering between right-aligned bus data and the word-wide SRAM:
// byte enables and replicated write data, plus read-data extraction.
module bus_lane_align
  import bus_mem_ctrl_pkg::*;
(
  input  logic [1:0]  memType,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wrData,
  input  logic [31:0] rdData,
  output logic [3:0]  byteEn,
  output logic [31:0] wrLanes,
  output logic [31:0] rdAligned
);

  logic [31:0] shifted;

  // Every lane carries the operand, so the SRAM picks the right bytes via byteEn alone.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wrLanes[8*gi +: 8] = (memType == WORD) ? wrData[8*gi +: 8] :
                                (memType == HALF) ? wrData[8*(gi%2) +: 8] :
                                                    wrData[7:0];
  end

  always_comb begin
    byteEn    = 4'b0000;
    rdAligned = '0;
    shifted   = rdData >> {addrLo, 3'b000};
    case (memType)
      BYTE: begin
        byteEn    = 4'b0001 << addrLo;
        rdAligned = {24'b0, shifted[7:0]};
      end
      HALF: begin
        byteEn    = 4'b0011 << addrLo;
        rdAligned = {16'b0, shifted[15:0]};
      end
      WORD: begin
        byteEn    = 4'hF;
        rdAligned = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_mem_ctrl.sv
// DataBus slave that turns BYTE/HALF/WORD requests into single byte-enabled
// SRAM word accesses, with programmable wait states and access checking.
module bus_mem_ctrl
  import bus_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              bus_read,
  input  logic              bus_write,
  input  logic [31:0]       bus_addr,
  input  logic [1:0]        bus_mem_type,
  input  logic [31:0]       bus_data_out,
  output logic [31:0]       bus_data_in,
  output logic              bus_ready,
  output logic              bus_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  BusCtrlState             stateReg, stateNext;
  logic [ADDR_W+1:0]       addrReg;
  logic [1:0]              typeReg;
  logic [31:0]             dataReg;
  logic                    writeReg;
  logic                    errReg;
  logic [WAIT_CNT_W-1:0]   waitCntReg;
  logic [31:0]             dataInReg;

  logic                    request;
  logic                    reqErr;
  logic [3:0]              laneBe;
  logic [31:0]             laneWdata;
  logic [31:0]             laneRdata;

  assign request     = bus_read | bus_write;
  assign bus_data_in = dataInReg;

  always_comb begin
    reqErr = (bus_read & bus_write)
           || (bus_mem_type == 2'd3)
           || ((bus_mem_type == WORD) && (bus_addr[1:0] != 2'b00))
           || ((bus_mem_type == HALF) && bus_addr[0])
           || ((bus_addr >> (ADDR_W + 2)) != 32'd0);
  end

  bus_lane_align u_lane (
    .memType  (typeReg),
    .addrLo   (addrReg[1:0]),
    .wrData   (dataReg),
    .rdData   (mem_rdata),
    .byteEn   (laneBe),
    .wrLanes  (laneWdata),
    .rdAligned(laneRdata)
  );

  always_comb begin
    stateNext = stateReg;
    bus_ready = 1'b0;
    bus_err   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    case (stateReg)
      IDLE: begin
        if (request) begin
          if (reqErr)               stateNext = DONE;
          else if (WAIT_STATES > 0) stateNext = WAIT;
          else                      stateNext = ACCESS;
        end
      end
      WAIT: begin
        if (waitCntReg == '0) stateNext = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = writeReg;
        mem_be    = laneBe;
        mem_addr  = addrReg[ADDR_W+1:2];
        mem_wdata = laneWdata;
        stateNext = writeReg ? DONE : CAPTURE;
      end
      CAPTURE: stateNext = DONE;
      DONE: begin
        bus_ready = 1'b1;
        bus_err   = errReg;
        stateNext = RECOVER;
      end
      // Master still holds its request during the ready edge; skip a cycle.
      RECOVER: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      stateReg   <= IDLE;
      addrReg    <= '0;
      typeReg    <= 2'b00;
      dataReg    <= '0;
      writeReg   <= 1'b0;
      errReg     <= 1'b0;
      waitCntReg <= '0;
      dataInReg  <= '0;
    end else begin
      stateReg <= stateNext;
      case (stateReg)
        IDLE: begin
          if (request) begin
            addrReg    <= bus_addr[ADDR_W+1:0];
            typeReg    <= bus_mem_type;
            dataReg    <= bus_data_out;
            writeReg   <= bus_write;
            errReg     <= reqErr;
            waitCntReg <= WAIT_CNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
            if (reqErr) dataInReg <= '0;
          end
        end
        WAIT:    waitCntReg <= waitCntReg - 1'b1;
        ACCESS:  if (writeReg) dataInReg <= '0;
        CAPTURE: dataInReg <= laneRdata;
        default: ;
      endcase
    end
  end

endmodule
